// File: rtl/sig_conv_enc_if.sv
// Data/control bundle for the tail-biting convolutional encoder.
// Signal suffixes are named from the encoder's point of view.
interface sig_conv_enc_if;
  logic       done_rst_i;
  logic [5:0] di_init_i;
  logic       di_i;
  logic       di_vld_i;
  logic [1:0] do_o;
  logic       do_vld_o;
  logic       frame_done_o;
  logic       tb_err_o;

  modport slave (
    input  done_rst_i, di_init_i, di_i, di_vld_i,
    output do_o, do_vld_o, frame_done_o, tb_err_o
  );

  modport master (
    output done_rst_i, di_init_i, di_i, di_vld_i,
    input  do_o, do_vld_o, frame_done_o, tb_err_o
  );
endinterface

// File: rtl/sig_conv_enc.sv
// Rate-1/2 K=7 tail-biting convolutional encoder (g0=133, g1=171 octal).
// One registered coded pair per accepted bit, latency 1 cycle, no backpressure.
module sig_conv_enc #(
  parameter int FRAME_BITS = 32
) (
  input  logic          clk,
  input  logic          rst,
  sig_conv_enc_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e     state_q, state_d;
  logic [5:0] sr_q, sr_d;
  logic [5:0] init_q, init_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] do_q, do_d;
  logic       do_vld_q, do_vld_d;
  logic       frame_done_q, frame_done_d;
  logic       tb_err_q, tb_err_d;

  logic [5:0] sr_load, sr_cur, sr_nxt, init_ref;
  logic [7:0] cnt_nxt;
  logic       bit_a, bit_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      init_q       <= '0;
      cnt_q        <= '0;
      do_q         <= '0;
      do_vld_q     <= 1'b0;
      frame_done_q <= 1'b0;
      tb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      init_q       <= init_d;
      cnt_q        <= cnt_d;
      do_q         <= do_d;
      do_vld_q     <= do_vld_d;
      frame_done_q <= frame_done_d;
      tb_err_q     <= tb_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    init_d       = init_q;
    cnt_d        = cnt_q;
    do_d         = do_q;
    do_vld_d     = 1'b0;
    frame_done_d = 1'b0;
    tb_err_d     = 1'b0;

    // di_init bit 5 is the most recently transmitted bit, so it lands in sr[0].
    for (int k = 0; k < 6; k++) begin
      sr_load[k] = bus.di_init_i[5-k];
    end

    sr_cur   = (state_q == IDLE) ? sr_load : sr_q;
    init_ref = (state_q == IDLE) ? sr_load : init_q;
    cnt_nxt  = (state_q == IDLE) ? 8'd1 : cnt_q + 8'd1;
    bit_a    = bus.di_i ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[4] ^ sr_cur[5];
    bit_b    = bus.di_i ^ sr_cur[0] ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[5];
    sr_nxt   = {sr_cur[4:0], bus.di_i};

    if (bus.done_rst_i) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
      do_d    = '0;
    end else if (bus.di_vld_i) begin
      sr_d     = sr_nxt;
      init_d   = init_ref;
      cnt_d    = cnt_nxt;
      do_d     = {bit_b, bit_a};
      do_vld_d = 1'b1;
      if (cnt_nxt == 8'(FRAME_BITS)) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
        tb_err_d     = (sr_nxt != init_ref);
      end else begin
        state_d = RUN;
      end
    end
  end

  assign bus.do_o         = do_q;
  assign bus.do_vld_o     = do_vld_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.tb_err_o     = tb_err_q;

endmodule

// File: tb/tb_sig_conv_enc.sv
// Directed, table-driven bench for sig_conv_enc with hand-computed coded pairs.
module tb_sig_conv_enc;

  logic clk = 1'b0;
  logic rst;

  sig_conv_enc_if bus ();

  sig_conv_enc #(.FRAME_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  init;
    logic [31:0] bits;   // bit i is the i-th transmitted bit
    logic [31:0] exp_a;  // bit i is A of pair i
    logic [31:0] exp_b;
    logic        exp_err;
    logic        gaps;   // 3 idle cycles after the 5th and 20th bits
  } vec_t;

  vec_t vecs [7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {do,vld,done,err}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.do_o, bus.do_vld_o, bus.frame_done_o, bus.tb_err_o};
  endfunction

  task automatic run_frame(input int idx, input int nbits);
    vec_t v;
    logic [4:0] exp;
    v = vecs[idx];
    for (int i = 0; i < nbits; i++) begin
      // di_init is only meaningful on the first bit; scramble it afterwards
      bus.di_init_i = (i == 0) ? v.init : ~v.init;
      bus.di_i      = v.bits[i];
      bus.di_vld_i  = 1'b1;
      @(posedge clk);
      #1;
      exp = {v.exp_b[i], v.exp_a[i], 1'b1, (i == 31), (i == 31) & v.exp_err};
      check($sformatf("v%0d.bit%0d", idx, i), outs(), exp);
      if (v.gaps && (i == 4 || i == 19)) begin
        for (int g = 0; g < 3; g++) begin
          bus.di_vld_i = 1'b0;
          bus.di_i     = ~v.bits[i];
          @(posedge clk);
          #1;
          check($sformatf("v%0d.gap%0d_%0d", idx, i, g), outs(),
                {v.exp_b[i], v.exp_a[i], 3'b000});
        end
      end
    end
  endtask

  initial begin
    //          init    bits           exp_a          exp_b          err   gaps
    vecs[0] = '{6'h00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{6'h00, 32'h0000_0001, 32'h0000_006D, 32'h0000_004F, 1'b0, 1'b0};
    vecs[3] = '{6'h00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0};
    vecs[4] = '{6'h20, 32'h0000_0000, 32'h0000_0036, 32'h0000_0027, 1'b1, 1'b0};
    vecs[5] = '{6'h20, 32'h8000_0000, 32'h8000_0036, 32'h8000_0027, 1'b0, 1'b0};
    vecs[6] = '{6'h20, 32'h8000_0000, 32'h8000_0036, 32'h8000_0027, 1'b0, 1'b1};

    rst            = 1'b1;
    bus.done_rst_i = 1'b0;
    bus.di_init_i  = 6'h00;
    bus.di_i       = 1'b0;
    bus.di_vld_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), 5'b00000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All table frames streamed back to back with no idle cycle in between
    for (int idx = 0; idx < 7; idx++) begin
      run_frame(idx, 32);
    end
    bus.di_vld_i = 1'b0;
    @(posedge clk);
    #1;
    check("idle_hold", outs(), {2'b11, 3'b000});

    // Frame abort at the 11th bit, coincident di_vld discarded
    run_frame(2, 10);
    bus.done_rst_i = 1'b1;
    bus.di_vld_i   = 1'b1;
    bus.di_i       = 1'b1;
    @(posedge clk);
    #1;
    check("done_rst", outs(), 5'b00000);
    bus.done_rst_i = 1'b0;
    run_frame(4, 32);
    run_frame(0, 32);

    // Asynchronous reset mid-frame, then a fresh frame
    run_frame(5, 15);
    bus.di_vld_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 5'b00000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(5, 32);
    bus.di_vld_i = 1'b0;
    @(posedge clk);
    #1;
    check("final_hold", outs(), {2'b11, 3'b000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
